tc_pl_cap_gain_seq: RTL

// - Capture gain sequencer; sits directly downstream of the capture GP config register block.
// - On cap_start, steps through gain settings 0..cap_gain_number.
// - For each gain: drives relay/lmh/DAC A/B, waits settle + LD delay, fires ld_trig, dwells cycle count.
// - Drives cap_cing back upstream, which freezes the config registers for the whole capture.

---
 rtl/tc_pl_cap_pkg.sv | 21 ++
 rtl/tc_pl_cap_down_cnt.sv | 29 ++
 rtl/tc_pl_cap_gain_seq.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/tc_pl_cap_pkg.sv
// Shared definitions for the capture gain sequencer: state encoding and default widths.
// The capture GP config register block sizes its buses with the same widths.
package tc_pl_cap_pkg;

    localparam int unsigned CapCycW  = 18;
    localparam int unsigned CapDelW  = 32;
    localparam int unsigned CapDacW  = 32;
    localparam int unsigned CapLmhW  = 6;
    localparam int unsigned CapRlyW  = 4;
    localparam int unsigned CapGnW   = 3;
    localparam int unsigned NumGains = 4;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StLddel,
        StRun,
        StDone
    } cap_state_e;

endpackage

// File: rtl/tc_pl_cap_down_cnt.sv
// Loadable down-counter with zero flag; decrement stops at zero.
module tc_pl_cap_down_cnt
    import tc_pl_cap_pkg::*;
#(
    parameter int unsigned W = CapDelW
) (
    input  logic         clk125,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk125 or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/tc_pl_cap_gain_seq.sv
// Capture gain sequencer: steps gains 0..gn, per gain drives relay/lmh/DAC, waits settle and
// LD delay, fires ld_trig, then dwells. cap_cing freezes the upstream config while busy.
module tc_pl_cap_gain_seq
    import tc_pl_cap_pkg::*;
#(
    parameter int unsigned CYC_W = CapCycW,
    parameter int unsigned DEL_W = CapDelW,
    parameter int unsigned DAC_W = CapDacW,
    parameter int unsigned LMH_W = CapLmhW,
    parameter int unsigned RLY_W = CapRlyW,
    parameter int unsigned GN_W  = CapGnW
) (
    input  logic                  clk125,
    input  logic                  rst,
    input  logic                  cap_start,
    input  logic                  cap_abort,
    input  logic [GN_W-1:0]       cap_gain_number,
    input  logic [DEL_W-1:0]      cap_gain_del,
    input  logic [4*CYC_W-1:0]    cap_cycle_bus,
    input  logic [4*DEL_W-1:0]    cap_lddel_bus,
    input  logic [4*DAC_W-1:0]    cap_daca_bus,
    input  logic [4*DAC_W-1:0]    cap_dacb_bus,
    input  logic [4*LMH_W-1:0]    cap_lmh_bus,
    input  logic [4*RLY_W-1:0]    cap_relay_bus,
    output logic                  cap_cing,
    output logic [1:0]            gain_idx,
    output logic [DAC_W-1:0]      dac_a,
    output logic [DAC_W-1:0]      dac_b,
    output logic [LMH_W-1:0]      lmh,
    output logic [RLY_W-1:0]      relay,
    output logic                  ld_trig,
    output logic                  cap_done
);

    localparam logic [GN_W-1:0] GnMax = GN_W'(NumGains - 1);

    // Per-gain views of the upstream buses; no local copies since upstream is frozen.
    logic [CYC_W-1:0] cyc_arr   [NumGains];
    logic [DEL_W-1:0] lddel_arr [NumGains];
    logic [DAC_W-1:0] daca_arr  [NumGains];
    logic [DAC_W-1:0] dacb_arr  [NumGains];
    logic [LMH_W-1:0] lmh_arr   [NumGains];
    logic [RLY_W-1:0] relay_arr [NumGains];

    for (genvar g = 0; g < NumGains; g++) begin : g_slice
        assign cyc_arr[g]   = cap_cycle_bus[g*CYC_W +: CYC_W];
        assign lddel_arr[g] = cap_lddel_bus[g*DEL_W +: DEL_W];
        assign daca_arr[g]  = cap_daca_bus[g*DAC_W +: DAC_W];
        assign dacb_arr[g]  = cap_dacb_bus[g*DAC_W +: DAC_W];
        assign lmh_arr[g]   = cap_lmh_bus[g*LMH_W +: LMH_W];
        assign relay_arr[g] = cap_relay_bus[g*RLY_W +: RLY_W];
    end

    // Counter preload so a state lasts max(n,1) cycles.
    function automatic logic [DEL_W-1:0] span_m1(input logic [DEL_W-1:0] n);
        return (n == '0) ? '0 : n - DEL_W'(1);
    endfunction

    cap_state_e       state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [1:0]       gn_q, gn_d;
    logic [DEL_W-1:0] gd_q, gd_d;
    logic             ld_trig_q, ld_trig_d;
    logic [DAC_W-1:0] dac_a_q, dac_b_q;
    logic [LMH_W-1:0] lmh_q;
    logic [RLY_W-1:0] relay_q;

    logic             cnt_load, cnt_dec, cnt_zero;
    logic [DEL_W-1:0] cnt_val;
    logic             fld_load, fld_clr;

    tc_pl_cap_down_cnt #(
        .W (DEL_W)
    ) u_cnt (
        .clk125   (clk125),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        gn_d      = gn_q;
        gd_d      = gd_q;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        cnt_val   = '0;
        fld_load  = 1'b0;
        fld_clr   = 1'b0;
        ld_trig_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cap_start) begin
                    state_d  = StSetup;
                    idx_d    = 2'd0;
                    gn_d     = (cap_gain_number > GnMax) ? 2'd3 : cap_gain_number[1:0];
                    gd_d     = cap_gain_del;
                    cnt_load = 1'b1;
                    cnt_val  = span_m1(cap_gain_del);
                    fld_load = 1'b1;
                end
            end
            StSetup: begin
                if (cnt_zero) begin
                    state_d  = StLddel;
                    cnt_load = 1'b1;
                    cnt_val  = span_m1(lddel_arr[idx_q]);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StLddel: begin
                if (cnt_zero) begin
                    state_d   = StRun;
                    cnt_load  = 1'b1;
                    cnt_val   = span_m1(DEL_W'(cyc_arr[idx_q]));
                    ld_trig_d = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StRun: begin
                if (cnt_zero) begin
                    if (idx_q == gn_q) begin
                        state_d = StDone;
                    end else begin
                        state_d  = StSetup;
                        idx_d    = idx_q + 2'd1;
                        cnt_load = 1'b1;
                        cnt_val  = span_m1(gd_q);
                        fld_load = 1'b1;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                idx_d   = 2'd0;
                fld_clr = 1'b1;
            end
            default: begin
                state_d = StIdle;
                idx_d   = 2'd0;
                fld_clr = 1'b1;
            end
        endcase
        // Abort overrides everything, including a same-cycle start.
        if (cap_abort) begin
            state_d   = StIdle;
            idx_d     = 2'd0;
            cnt_load  = 1'b1;
            cnt_val   = '0;
            cnt_dec   = 1'b0;
            fld_load  = 1'b0;
            fld_clr   = 1'b1;
            ld_trig_d = 1'b0;
        end
    end

    always_ff @(posedge clk125 or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            idx_q     <= 2'd0;
            gn_q      <= 2'd0;
            gd_q      <= '0;
            ld_trig_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            gn_q      <= gn_d;
            gd_q      <= gd_d;
            ld_trig_q <= ld_trig_d;
        end
    end

    always_ff @(posedge clk125 or posedge rst) begin
        if (rst) begin
            dac_a_q <= '0;
            dac_b_q <= '0;
            lmh_q   <= '0;
            relay_q <= '0;
        end else if (fld_clr) begin
            dac_a_q <= '0;
            dac_b_q <= '0;
            lmh_q   <= '0;
            relay_q <= '0;
        end else if (fld_load) begin
            dac_a_q <= daca_arr[idx_d];
            dac_b_q <= dacb_arr[idx_d];
            lmh_q   <= lmh_arr[idx_d];
            relay_q <= relay_arr[idx_d];
        end
    end

    assign cap_cing = (state_q != StIdle);
    assign cap_done = (state_q == StDone);
    assign gain_idx = idx_q;
    assign ld_trig  = ld_trig_q;
    assign dac_a    = dac_a_q;
    assign dac_b    = dac_b_q;
    assign lmh      = lmh_q;
    assign relay    = relay_q;

endmodule
